vga_capture: RTL

- Video input capture block: the write-side counterpart of the framebuffer-reading VGA output controller.
- Samples an incoming parallel video stream (HS/VS/BLANK/RGB) on pixel_clk and pushes active pixels through an async_fifo (DATA_WIDTH=33).
- A Wishbone classic master on wshb clk drains the FIFO and writes one 32-bit word per pixel into SDRAM, starting at ADR_BASE, in raster order.

---
 rtl/vga_capture_if.sv | 27 ++
 rtl/vga_capture.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_if.sv
// Wishbone classic bus bundle shared by the capture master and its slave.
// clk/rst come in as interface ports so both ends see the same bus clock.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      input  clk, rst, ack, dat_sm,
      output adr, dat_ms, we, stb, cyc, sel, cti, bte
   );

   modport slave (
      input  clk, rst, adr, dat_ms, we, stb, cyc, sel, cti, bte,
      output ack, dat_sm
   );
endinterface

// File: rtl/vga_capture.sv
// Video input capture: samples a parallel HS/VS/BLANK/RGB stream on pixel_clk,
// queues active pixels through a dual-clock FIFO and writes them to memory as
// 32-bit words over a Wishbone classic master, one word per pixel, raster order.
// Bit 32 of each FIFO word marks the first pixel of a frame and realigns the
// write address to ADR_BASE.

// Dual-clock FIFO with Gray-coded pointers and two-flop pointer synchronisers.
// Read data is show-ahead: o_rdata is the head word whenever o_rempty is low.
module async_fifo #(
   parameter int unsigned DATA_WIDTH = 33,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  i_wclk,
   input  logic                  i_wrst,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_wfull,
   input  logic                  i_rclk,
   input  logic                  i_rrst,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rempty
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [ADDR_WIDTH:0]   r_wbin, r_wgray, r_rbin, r_rgray;
   logic [ADDR_WIDTH:0]   r_wq1, r_wq2;   // read pointer seen in write domain
   logic [ADDR_WIDTH:0]   r_rq1, r_rq2;   // write pointer seen in read domain
   logic [ADDR_WIDTH:0]   w_wbin_next, w_wgray_next, w_rbin_next, w_rgray_next;
   logic                  w_push, w_pop;

   assign w_push       = i_wr_en && !o_wfull;
   assign w_pop        = i_rd_en && !o_rempty;
   assign w_wbin_next  = r_wbin + 1'b1;
   assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
   assign w_rbin_next  = r_rbin + 1'b1;
   assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

   assign o_wfull  = (r_wgray == {~r_wq2[ADDR_WIDTH:ADDR_WIDTH-1], r_wq2[ADDR_WIDTH-2:0]});
   assign o_rempty = (r_rgray == r_rq2);
   assign o_rdata  = r_mem[r_rbin[ADDR_WIDTH-1:0]];

   // Storage write.
   // NOTE: the memory array has no reset; a word is only read after the
   // pointer that covers it has crossed domains, so stale contents never escape.
   always_ff @(posedge i_wclk) begin
      if (w_push) r_mem[r_wbin[ADDR_WIDTH-1:0]] <= i_wdata;
   end

   // Write pointer and read-pointer synchroniser.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge i_wclk or posedge i_wrst) begin
      if (i_wrst) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_wq1   <= '0;
         r_wq2   <= '0;
      end else begin
         r_wq1 <= r_rgray;
         r_wq2 <= r_wq1;
         if (w_push) begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
         end
      end
   end

   // Read pointer and write-pointer synchroniser.
   always_ff @(posedge i_rclk or posedge i_rrst) begin
      if (i_rrst) begin
         r_rbin  <= '0;
         r_rgray <= '0;
         r_rq1   <= '0;
         r_rq2   <= '0;
      end else begin
         r_rq1 <= r_wgray;
         r_rq2 <= r_rq1;
         if (w_pop) begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
         end
      end
   end
endmodule

module vga_capture #(
   parameter int unsigned HDISP    = 800,
   parameter int unsigned VDISP    = 480,
   parameter logic [31:0] ADR_BASE = 32'h0,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic        pixel_clk,
   input  logic        pixel_rst,
   input  logic        vid_vs,
   input  logic        vid_hs,
   input  logic        vid_blank,
   input  logic [23:0] vid_rgb,
   output logic        frame_done,
   output logic        overflow,
   output logic        frame_err,
   wshb_if.master      wshb_ifm
);
   localparam int unsigned      PIX_TOTAL = HDISP * VDISP;
   localparam int unsigned      CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIX_TOTAL - 1);
   localparam logic [31:0]      ADR_LAST  = ADR_BASE + 32'(4 * (PIX_TOTAL - 1));

   typedef enum logic [1:0] {PX_WAIT_VS, PX_CAPTURE, PX_DROP} px_state_t;
   typedef enum logic       {BS_IDLE, BS_BUS} bus_state_t;

   // ---------------- pixel_clk domain ----------------
   logic             r_vs, r_vs_d, r_hs, r_blank;
   logic [23:0]      r_rgb;
   px_state_t        r_px_state, w_px_next;
   logic [CNT_W-1:0] r_pix_cnt, w_cnt_next, w_cnt_base;
   logic             r_sof_pending, w_sof_next, w_sof_eff;
   logic             r_frame_done, w_done_next;
   logic             r_overflow, w_ovf_next;
   logic             r_frame_err, w_ferr_next;
   logic             w_vs_fall, w_capt;
   logic [1:0]       r_wrst_sync;
   logic             w_fifo_wrst, w_fifo_wr, w_fifo_full;
   logic [32:0]      w_fifo_wdata;

   // ---------------- bus clock domain ----------------
   bus_state_t       r_bus_state, w_bus_next;
   logic [31:0]      r_hold, w_hold_next;
   logic [31:0]      r_adr, w_adr_next;
   logic             w_fifo_rd, w_fifo_empty, w_can_pop;
   logic [32:0]      w_fifo_rdata;
   logic             w_unused;

   assign w_unused = ^{wshb_ifm.dat_sm, r_hs};

   // Input stage: register the video bus once; keep previous VS for edge detect.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         r_vs    <= 1'b1;
         r_vs_d  <= 1'b1;
         r_hs    <= 1'b1;
         r_blank <= 1'b0;
         r_rgb   <= '0;
      end else begin
         r_vs    <= vid_vs;
         r_vs_d  <= r_vs;
         r_hs    <= vid_hs;
         r_blank <= vid_blank;
         r_rgb   <= vid_rgb;
      end
   end

   assign w_vs_fall = r_vs_d && !r_vs;

   // Bus reset reaches the FIFO write side asynchronously, released on pixel_clk.
   always_ff @(posedge pixel_clk or posedge wshb_ifm.rst) begin
      if (wshb_ifm.rst) r_wrst_sync <= 2'b11;
      else              r_wrst_sync <= {r_wrst_sync[0], 1'b0};
   end

   assign w_fifo_wrst = r_wrst_sync[1];

   // Pixel FSM state and counters.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         r_px_state    <= PX_WAIT_VS;
         r_pix_cnt     <= '0;
         r_sof_pending <= 1'b0;
         r_frame_done  <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_px_state    <= w_px_next;
         r_pix_cnt     <= w_cnt_next;
         r_sof_pending <= w_sof_next;
         r_frame_done  <= w_done_next;
         r_overflow    <= w_ovf_next;
         r_frame_err   <= w_ferr_next;
      end
   end

   // Pixel FSM next state: a VS fall restarts the frame in any state and the
   // pixel arriving in that same cycle is captured as the new frame's first.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      w_px_next   = r_px_state;
      w_cnt_next  = r_pix_cnt;
      w_sof_next  = r_sof_pending;
      w_done_next = 1'b0;
      w_ovf_next  = r_overflow;
      w_ferr_next = r_frame_err;
      w_fifo_wr   = 1'b0;
      w_cnt_base  = r_pix_cnt;
      w_sof_eff   = r_sof_pending;
      w_capt      = (r_px_state == PX_CAPTURE);

      if (w_vs_fall) begin
         if (r_px_state == PX_CAPTURE) w_ferr_next = 1'b1;
         w_capt     = 1'b1;
         w_cnt_base = '0;
         w_sof_eff  = 1'b1;
         w_px_next  = PX_CAPTURE;
         w_cnt_next = '0;
         w_sof_next = 1'b1;
      end

      if (w_capt && r_blank) begin
         if (w_fifo_full) begin
            w_ovf_next = 1'b1;
            w_px_next  = PX_DROP;
         end else begin
            w_fifo_wr  = 1'b1;
            w_sof_next = 1'b0;
            w_cnt_next = w_cnt_base + 1'b1;
            if (w_cnt_base == LAST_PIX) begin
               w_done_next = 1'b1;
               w_px_next   = PX_WAIT_VS;
            end
         end
      end
   end

   assign w_fifo_wdata = {w_sof_eff, 8'h00, r_rgb};
   assign frame_done   = r_frame_done;
   assign overflow     = r_overflow;
   assign frame_err    = r_frame_err;

   async_fifo #(
      .DATA_WIDTH (33),
      .ADDR_WIDTH (FIFO_AW)
   ) u_fifo (
      .i_wclk   (pixel_clk),
      .i_wrst   (w_fifo_wrst),
      .i_wr_en  (w_fifo_wr),
      .i_wdata  (w_fifo_wdata),
      .o_wfull  (w_fifo_full),
      .i_rclk   (wshb_ifm.clk),
      .i_rrst   (wshb_ifm.rst),
      .i_rd_en  (w_fifo_rd),
      .o_rdata  (w_fifo_rdata),
      .o_rempty (w_fifo_empty)
   );

   // Bus FSM state, holding register and write address.
   always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
      if (wshb_ifm.rst) begin
         r_bus_state <= BS_IDLE;
         r_hold      <= '0;
         r_adr       <= ADR_BASE;
      end else begin
         r_bus_state <= w_bus_next;
         r_hold      <= w_hold_next;
         r_adr       <= w_adr_next;
      end
   end

   // Bus FSM next state: pop when idle or in the ack cycle so requests can run
   // back to back; SOF words snap the address to ADR_BASE, others step by 4.
   always_comb begin
      w_bus_next  = r_bus_state;
      w_hold_next = r_hold;
      w_adr_next  = r_adr;
      w_fifo_rd   = 1'b0;
      w_can_pop   = (r_bus_state == BS_IDLE) || wshb_ifm.ack;

      if (r_bus_state == BS_BUS && wshb_ifm.ack) w_bus_next = BS_IDLE;

      if (w_can_pop && !w_fifo_empty) begin
         w_fifo_rd   = 1'b1;
         w_hold_next = w_fifo_rdata[31:0];
         w_bus_next  = BS_BUS;
         if (w_fifo_rdata[32] || r_adr == ADR_LAST) w_adr_next = ADR_BASE;
         else                                       w_adr_next = r_adr + 32'd4;
      end
   end

   assign wshb_ifm.cyc    = (r_bus_state == BS_BUS);
   assign wshb_ifm.stb    = (r_bus_state == BS_BUS);
   assign wshb_ifm.we     = (r_bus_state == BS_BUS);
   assign wshb_ifm.adr    = r_adr;
   assign wshb_ifm.dat_ms = r_hold;
   assign wshb_ifm.sel    = 4'b1111;
   assign wshb_ifm.cti    = 3'b000;
   assign wshb_ifm.bte    = 2'b00;
endmodule
